// File: rtl/fetcher_assoc_if.sv
// Fetcher bus bundle: predictor, memctrl, rob and commander signals.
// slave = fetch stage side, master = environment side.
interface fetcher_assoc_if #(
   parameter int ADDR_WIDTH      = 32,
   parameter int INST_WIDTH      = 32,
   parameter int WORDS_PER_BLOCK = 4
) ();
   logic                                  rdy;
   logic                                  full_sign;
   logic                                  rollback_sign_from_rob;
   logic [ADDR_WIDTH-1:0]                 pc_from_rob;
   logic                                  predicted_jump_sign_from_pdt;
   logic [ADDR_WIDTH-1:0]                 predicted_jump_target_pc_from_pdt;
   logic [ADDR_WIDTH-1:0]                 predict_pc_to_pdt;
   logic [INST_WIDTH-1:0]                 predict_inst_to_pdt;
   logic                                  finish_sign_from_memctrl;
   logic [WORDS_PER_BLOCK*INST_WIDTH-1:0] inst_block_from_memctrl;
   logic [ADDR_WIDTH-1:0]                 pc_to_memctrl;
   logic                                  enable_sign_to_memctrl;
   logic                                  rollback_sign_to_memctrl;
   logic                                  finish_sign_to_cmd;
   logic [ADDR_WIDTH-1:0]                 pc_to_cmd;
   logic [INST_WIDTH-1:0]                 inst_to_cmd;
   logic                                  predicted_jump_sign_to_cmd;
   logic [ADDR_WIDTH-1:0]                 rollback_pc_to_cmd;

   modport slave (
      input  rdy, full_sign, rollback_sign_from_rob, pc_from_rob,
      input  predicted_jump_sign_from_pdt, predicted_jump_target_pc_from_pdt,
      input  finish_sign_from_memctrl, inst_block_from_memctrl,
      output predict_pc_to_pdt, predict_inst_to_pdt,
      output pc_to_memctrl, enable_sign_to_memctrl, rollback_sign_to_memctrl,
      output finish_sign_to_cmd, pc_to_cmd, inst_to_cmd,
      output predicted_jump_sign_to_cmd, rollback_pc_to_cmd
   );

   modport master (
      output rdy, full_sign, rollback_sign_from_rob, pc_from_rob,
      output predicted_jump_sign_from_pdt, predicted_jump_target_pc_from_pdt,
      output finish_sign_from_memctrl, inst_block_from_memctrl,
      input  predict_pc_to_pdt, predict_inst_to_pdt,
      input  pc_to_memctrl, enable_sign_to_memctrl, rollback_sign_to_memctrl,
      input  finish_sign_to_cmd, pc_to_cmd, inst_to_cmd,
      input  predicted_jump_sign_to_cmd, rollback_pc_to_cmd
   );
endinterface

// File: rtl/fetcher_assoc.sv
// Fetch stage with N-way set-associative icache and per-set LRU.
// Optional next-line prefetch: define ICACHE_NEXT_LINE_PREFETCH_EN.
module fetcher_assoc #(
   parameter int ADDR_WIDTH      = 32,
   parameter int INST_WIDTH      = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int SETS            = 16,
   parameter int WAYS            = 2
) (
   input logic             clk,
   input logic             rst,
   fetcher_assoc_if.slave  bus
);
   localparam int WPB_W = $clog2(WORDS_PER_BLOCK);
   localparam int OFF   = WPB_W + 2;
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_WIDTH - OFF - IDX_W;
   localparam int BLK_W = WORDS_PER_BLOCK * INST_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(4);
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
   localparam logic [ADDR_WIDTH-1:0] BLK_B = ADDR_WIDTH'(WORDS_PER_BLOCK * 4);
`endif

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
   typedef enum logic [1:0] {IDLE, FETCH, PREFETCH} state_e;
`else
   typedef enum logic [1:0] {IDLE, FETCH} state_e;
`endif

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   mem_pc_q, mem_pc_d;
   logic [ADDR_WIDTH-1:0]   pc_cmd_q, pc_cmd_d;
   logic [ADDR_WIDTH-1:0]   rbpc_q, rbpc_d;
   logic [INST_WIDTH-1:0]   inst_q, inst_d;
   logic                    fin_q, fin_d;
   logic                    pj_q, pj_d;
   logic                    en_q, en_d;
   logic                    rb_q, rb_d;

   logic [WAYS-1:0][SETS-1:0] valid_q;
   logic [SETS-1:0]           lru_q;
   logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
   logic [BLK_W-1:0]          data_q [WAYS][SETS];

   logic [IDX_W-1:0]        idx;
   logic [TAG_W-1:0]        tag;
   logic [WPB_W-1:0]        wsel;
   logic                    hit;
   logic                    hit_way;
   logic [BLK_W-1:0]        hit_blk;
   logic [INST_WIDTH-1:0]   hit_word;
   logic                    issue;

   logic [IDX_W-1:0]        fill_idx;
   logic [TAG_W-1:0]        fill_tag;
   logic                    fill_way;
   logic                    fill_we;
   logic                    lru_we;

   always_comb begin : lookup
      idx      = pc_q[OFF+IDX_W-1:OFF];
      tag      = pc_q[ADDR_WIDTH-1:OFF+IDX_W];
      wsel     = pc_q[OFF-1:2];
      hit      = 1'b0;
      hit_way  = 1'b0;
      hit_word = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
            hit     = 1'b1;
            hit_way = 1'(w);
         end
      end
      hit_blk = data_q[hit_way][idx];
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
         if (wsel == WPB_W'(i)) hit_word = hit_blk[i*INST_WIDTH +: INST_WIDTH];
      end
   end

   // Refill target is the latched request address, not the live pc.
   always_comb begin : victim
      fill_idx = mem_pc_q[OFF+IDX_W-1:OFF];
      fill_tag = mem_pc_q[ADDR_WIDTH-1:OFF+IDX_W];
      fill_way = (WAYS == 1) ? 1'b0 : lru_q[fill_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][fill_idx]) fill_way = 1'(w);
      end
   end

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
   logic [ADDR_WIDTH-1:0] pf_pc;
   logic [IDX_W-1:0]      pf_idx;
   logic                  pf_hit;

   always_comb begin : pf_lookup
      pf_pc  = mem_pc_q + BLK_B;
      pf_idx = pf_pc[OFF+IDX_W-1:OFF];
      pf_hit = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][pf_idx] &&
             tag_q[w][pf_idx] == pf_pc[ADDR_WIDTH-1:OFF+IDX_W])
            pf_hit = 1'b1;
      end
   end
`endif

   assign issue = hit && !bus.full_sign;

   always_comb begin : next
      state_d  = state_q;
      pc_d     = pc_q;
      mem_pc_d = mem_pc_q;
      pc_cmd_d = pc_cmd_q;
      rbpc_d   = rbpc_q;
      inst_d   = inst_q;
      pj_d     = pj_q;
      fin_d    = 1'b0;
      en_d     = 1'b0;
      rb_d     = 1'b0;
      fill_we  = 1'b0;
      lru_we   = 1'b0;
      if (bus.rollback_sign_from_rob) begin
         pc_d    = bus.pc_from_rob;
         rb_d    = 1'b1;
         state_d = IDLE;
      end else begin
         if (issue) begin
            fin_d    = 1'b1;
            pc_cmd_d = pc_q;
            inst_d   = hit_word;
            rbpc_d   = pc_q + STEP;
            pj_d     = bus.predicted_jump_sign_from_pdt;
            pc_d     = pc_q + (bus.predicted_jump_sign_from_pdt ?
                               bus.predicted_jump_target_pc_from_pdt : STEP);
            lru_we   = (WAYS == 2);
         end
         unique case (state_q)
            IDLE: begin
               if (!hit) begin
                  mem_pc_d = {pc_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                  en_d     = 1'b1;
                  state_d  = FETCH;
               end
            end
            FETCH: begin
               if (bus.finish_sign_from_memctrl) begin
                  fill_we = 1'b1;
                  state_d = IDLE;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                  if (!pf_hit) begin
                     mem_pc_d = pf_pc;
                     en_d     = 1'b1;
                     state_d  = PREFETCH;
                  end
`endif
               end
            end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            PREFETCH: begin
               if (bus.finish_sign_from_memctrl) begin
                  fill_we = 1'b1;
                  state_d = IDLE;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         mem_pc_q <= '0;
         pc_cmd_q <= '0;
         rbpc_q   <= '0;
         inst_q   <= '0;
         fin_q    <= 1'b0;
         pj_q     <= 1'b0;
         en_q     <= 1'b0;
         rb_q     <= 1'b0;
         valid_q  <= '0;
         lru_q    <= '0;
      end else if (bus.rdy) begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         mem_pc_q <= mem_pc_d;
         pc_cmd_q <= pc_cmd_d;
         rbpc_q   <= rbpc_d;
         inst_q   <= inst_d;
         fin_q    <= fin_d;
         pj_q     <= pj_d;
         en_q     <= en_d;
         rb_q     <= rb_d;
         if (fill_we) valid_q[fill_way][fill_idx] <= 1'b1;
         if (lru_we)  lru_q[idx] <= ~hit_way;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.rdy && fill_we) begin
         tag_q[fill_way][fill_idx]  <= fill_tag;
         data_q[fill_way][fill_idx] <= bus.inst_block_from_memctrl;
      end
   end

   assign bus.predict_pc_to_pdt          = pc_q;
   assign bus.predict_inst_to_pdt        = hit ? hit_word : '0;
   assign bus.pc_to_memctrl              = mem_pc_q;
   assign bus.enable_sign_to_memctrl     = en_q;
   assign bus.rollback_sign_to_memctrl   = rb_q;
   assign bus.finish_sign_to_cmd         = fin_q;
   assign bus.pc_to_cmd                  = pc_cmd_q;
   assign bus.inst_to_cmd                = inst_q;
   assign bus.predicted_jump_sign_to_cmd = pj_q;
   assign bus.rollback_pc_to_cmd         = rbpc_q;
endmodule

// File: tb/tb_fetcher_assoc.sv
// Directed bench for fetcher_assoc: refill, issue, stall, predict,
// LRU eviction and rollback abort.
module tb_fetcher_assoc;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetcher_assoc_if #(
      .ADDR_WIDTH(32), .INST_WIDTH(32), .WORDS_PER_BLOCK(4)
   ) bus ();

   fetcher_assoc #(
      .ADDR_WIDTH(32), .INST_WIDTH(32), .WORDS_PER_BLOCK(4),
      .SETS(16), .WAYS(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0040_0093 : 32'hC0DE_0000 + a;
   endfunction

   function automatic logic [127:0] blk(input logic [31:0] a);
      logic [127:0] b;
      for (int i = 0; i < 4; i++) b[i*32 +: 32] = word(a + 32'(i * 4));
      return b;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_en(input logic [31:0] a);
      int n = 0;
      while (bus.enable_sign_to_memctrl !== 1'b1 && n < 16) begin
         tick();
         n++;
      end
      chk("req_en", 32'(bus.enable_sign_to_memctrl), 32'h1);
      chk("req_addr", bus.pc_to_memctrl, a);
   endtask

   task automatic serve(input logic [31:0] a);
      wait_en(a);
      tick();
      chk("en_pulse", 32'(bus.enable_sign_to_memctrl), 32'h0);
      bus.finish_sign_from_memctrl = 1'b1;
      bus.inst_block_from_memctrl  = blk(a);
      tick();
      bus.finish_sign_from_memctrl = 1'b0;
      chk("fill_hit", bus.predict_inst_to_pdt, word(a));
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      chk("pf_en", 32'(bus.enable_sign_to_memctrl), 32'h1);
      chk("pf_addr", bus.pc_to_memctrl, a + 32'h10);
      bus.finish_sign_from_memctrl = 1'b1;
      bus.inst_block_from_memctrl  = blk(a + 32'h10);
      tick();
      bus.finish_sign_from_memctrl = 1'b0;
`else
      tick();
`endif
      chk("iss_fin", 32'(bus.finish_sign_to_cmd), 32'h1);
      chk("iss_pc", bus.pc_to_cmd, a);
      chk("iss_inst", bus.inst_to_cmd, word(a));
      chk("iss_rbpc", bus.rollback_pc_to_cmd, a + 32'h4);
   endtask

   task automatic rb_to(input logic [31:0] a);
      bus.rollback_sign_from_rob = 1'b1;
      bus.pc_from_rob            = a;
      tick();
      bus.rollback_sign_from_rob = 1'b0;
      chk("rb_pulse", 32'(bus.rollback_sign_to_memctrl), 32'h1);
      chk("rb_pc", bus.predict_pc_to_pdt, a);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.rdy                               = 1'b0;
      bus.full_sign                         = 1'b0;
      bus.rollback_sign_from_rob            = 1'b0;
      bus.pc_from_rob                       = '0;
      bus.predicted_jump_sign_from_pdt      = 1'b0;
      bus.predicted_jump_target_pc_from_pdt = '0;
      bus.finish_sign_from_memctrl          = 1'b0;
      bus.inst_block_from_memctrl           = '0;
      tick();
      tick();
      chk("rst_fin", 32'(bus.finish_sign_to_cmd), 32'h0);
      chk("rst_en", 32'(bus.enable_sign_to_memctrl), 32'h0);
      chk("rst_rb", 32'(bus.rollback_sign_to_memctrl), 32'h0);
      chk("rst_pc", bus.predict_pc_to_pdt, 32'h0);
      chk("rst_pccmd", bus.pc_to_cmd, 32'h0);
      rst     = 1'b0;
      bus.rdy = 1'b1;

      // Cold miss at 0, refill, first issue.
      serve(32'h0);

      tick();
      chk("seq4_pc", bus.pc_to_cmd, 32'h4);
      chk("seq4_inst", bus.inst_to_cmd, 32'hC0DE_0004);
      bus.full_sign = 1'b1;
      tick();
      chk("full_fin", 32'(bus.finish_sign_to_cmd), 32'h0);
      chk("full_pc", bus.predict_pc_to_pdt, 32'h8);
      tick();
      chk("full_hold", bus.predict_pc_to_pdt, 32'h8);
      bus.full_sign = 1'b0;
      tick();
      chk("seq8_fin", 32'(bus.finish_sign_to_cmd), 32'h1);
      chk("seq8_pc", bus.pc_to_cmd, 32'h8);
      chk("seq8_rbpc", bus.rollback_pc_to_cmd, 32'hC);
      tick();
      chk("seqC_pc", bus.pc_to_cmd, 32'hC);
      chk("seqC_inst", bus.inst_to_cmd, 32'hC0DE_000C);
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      chk("pf_hit", bus.predict_inst_to_pdt, 32'hC0DE_0010);
      tick();
      chk("pf_noreq", 32'(bus.enable_sign_to_memctrl), 32'h0);
      chk("pf_iss", bus.pc_to_cmd, 32'h10);
`else
      chk("miss_10", bus.predict_inst_to_pdt, 32'h0);
`endif

      // Taken prediction at 0x4.
      rb_to(32'h4);
      bus.predicted_jump_sign_from_pdt      = 1'b1;
      bus.predicted_jump_target_pc_from_pdt = 32'h20;
      tick();
      bus.predicted_jump_sign_from_pdt = 1'b0;
      chk("pj_sign", 32'(bus.predicted_jump_sign_to_cmd), 32'h1);
      chk("pj_pccmd", bus.pc_to_cmd, 32'h4);
      chk("pj_next", bus.predict_pc_to_pdt, 32'h24);
      chk("rb_once", 32'(bus.rollback_sign_to_memctrl), 32'h0);

      // rdy low freezes everything, even a rollback.
      bus.rdy                    = 1'b0;
      bus.rollback_sign_from_rob = 1'b1;
      bus.pc_from_rob            = 32'h300;
      tick();
      tick();
      chk("hold_pc", bus.predict_pc_to_pdt, 32'h24);
      chk("hold_rb", 32'(bus.rollback_sign_to_memctrl), 32'h0);
      chk("hold_fin", 32'(bus.finish_sign_to_cmd), 32'h1);
      bus.rollback_sign_from_rob = 1'b0;
      bus.rdy                    = 1'b1;

      // Set 0: 0x000 in way 0, 0x100 in way 1, touch 0x000, then 0x200.
      rb_to(32'h100);
      serve(32'h100);
      rb_to(32'h0);
      chk("use0_hit", bus.predict_inst_to_pdt, 32'h0040_0093);
      tick();
      chk("use0_iss", bus.pc_to_cmd, 32'h0);
      rb_to(32'h200);
      serve(32'h200);
      rb_to(32'h0);
      chk("keep0_hit", bus.predict_inst_to_pdt, 32'h0040_0093);
      tick();
      chk("keep0_noreq", 32'(bus.enable_sign_to_memctrl), 32'h0);
      chk("keep0_fin", 32'(bus.finish_sign_to_cmd), 32'h1);
      rb_to(32'h100);
      chk("evict100", bus.predict_inst_to_pdt, 32'h0);
      tick();
      chk("re100_en", 32'(bus.enable_sign_to_memctrl), 32'h1);
      chk("re100_addr", bus.pc_to_memctrl, 32'h100);

      // Rollback during FETCH collides with refill data.
      bus.rollback_sign_from_rob   = 1'b1;
      bus.pc_from_rob              = 32'h40;
      bus.finish_sign_from_memctrl = 1'b1;
      bus.inst_block_from_memctrl  = blk(32'h100);
      tick();
      bus.rollback_sign_from_rob   = 1'b0;
      bus.finish_sign_from_memctrl = 1'b0;
      chk("abort_rb", 32'(bus.rollback_sign_to_memctrl), 32'h1);
      chk("abort_en", 32'(bus.enable_sign_to_memctrl), 32'h0);
      chk("abort_fin", 32'(bus.finish_sign_to_cmd), 32'h0);
      tick();
      chk("abort_rb1", 32'(bus.rollback_sign_to_memctrl), 32'h0);
      chk("req40_en", 32'(bus.enable_sign_to_memctrl), 32'h1);
      chk("req40_addr", bus.pc_to_memctrl, 32'h40);
      rb_to(32'h100);
      chk("stale_drop", bus.predict_inst_to_pdt, 32'h0);
      rb_to(32'h40);
      serve(32'h40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fetcher_assoc.md
Name: fetcher_assoc

Overview:
- Parametrised instruction fetch stage with an N-way set-associative icache and per-set LRU replacement.
- Sits between the predictor, memctrl, the rob and the commander.
- Each cycle it delivers at most one instruction and its predicted next pc to the commander.
- Refills whole blocks from memctrl on a miss and redirects on rob rollback.

Parameters:
- ADDR_WIDTH, 32, pc / memory address width.
- INST_WIDTH, 32, instruction width.
- WORDS_PER_BLOCK, 4, instructions per cache block; power of 2, ≥2.
- SETS, 16, number of sets; power of 2.
- WAYS, 2, associativity; 1 or 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; when low, all state holds
- full_sign  in  1  downstream full; blocks issue to commander
- rollback_sign_from_rob  in  1  redirect request
- pc_from_rob  in  ADDR_WIDTH  redirect target
- predicted_jump_sign_from_pdt  in  1  predictor says taken
- predicted_jump_target_pc_from_pdt  in  ADDR_WIDTH  taken offset, added to pc
- predict_pc_to_pdt  out  ADDR_WIDTH  current pc (combinational)
- predict_inst_to_pdt  out  INST_WIDTH  hit instruction, else 0 (combinational)
- finish_sign_from_memctrl  in  1  refill data valid
- inst_block_from_memctrl  in  WORDS_PER_BLOCK*INST_WIDTH  refill block; word 0 in LSBs
- pc_to_memctrl  out  ADDR_WIDTH  block-aligned refill address
- enable_sign_to_memctrl  out  1  one-cycle refill request pulse
- rollback_sign_to_memctrl  out  1  one-cycle abort pulse
- finish_sign_to_cmd  out  1  instruction valid
- pc_to_cmd  out  ADDR_WIDTH  pc of issued instruction
- inst_to_cmd  out  INST_WIDTH  issued instruction
- predicted_jump_sign_to_cmd  out  1  prediction attached to issued instruction
- rollback_pc_to_cmd  out  ADDR_WIDTH  pc+4 of issued instruction

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_BLOCK)+2.
  - word select = pc[OFF-1:2].
  - index = pc[OFF+log2(SETS)-1:OFF].
  - tag = remaining upper bits.
- Hit = any way of the indexed set is valid with a matching tag. The hit way's LRU bit is updated to "other way" on every issued hit.
- Reset (asynchronous):
  - pc=0; all valid bits=0; LRU=0; state=IDLE.
  - Every output register is 0, including finish_sign_to_cmd, enable_sign_to_memctrl and rollback_sign_to_memctrl.
- Priority order per cycle: rdy low (hold everything) > rollback > normal operation.
- Rollback:
  - pc<=pc_from_rob; finish_sign_to_cmd<=0; enable<=0; rollback_sign_to_memctrl<=1 for exactly one cycle; state<=IDLE.
  - A finish_sign_from_memctrl arriving in the same cycle is dropped; no cache write.
- Issue (hit && !full_sign), registered, one cycle after pc presented:
  - finish_sign_to_cmd<=1; pc_to_cmd<=pc; inst_to_cmd<=selected word; rollback_pc_to_cmd<=pc+4.
  - predicted_jump_sign_to_cmd<=predictor sign.
  - pc<=pc + (taken ? target : 4), modulo 2^ADDR_WIDTH.
- No issue: finish_sign_to_cmd<=0; pc holds.
- States:
  - IDLE: on miss, latch miss_pc<=pc; pc_to_memctrl<=pc with low OFF bits cleared; pulse enable one cycle; go FETCH.
  - FETCH: wait for finish_sign_from_memctrl. On finish, fill the set of miss_pc (not the current pc): choose the invalid way if any (way 0 first), else the LRU way. Write tag, data and valid; go IDLE.
  - A hit on the just-filled line is possible the following cycle.
- No new request is issued while in FETCH. enable and rollback pulses are deasserted in every cycle they are not explicitly set.

Optional Feature:
- Macro: ICACHE_NEXT_LINE_PREFETCH_EN.
- Enabled:
  - After a demand refill, if block miss_pc+WORDS_PER_BLOCK*4 is absent, enter PREFETCH: pulse enable with that address, and fill on finish using the same victim rule.
  - A demand miss on a different block while in PREFETCH waits for the prefetch to complete.
  - Rollback aborts the prefetch identically to a demand fetch.
- Disabled: no PREFETCH state; behaviour exactly as above.

Test Plan:
- Reset, then rdy=1, pc=0 miss -> one-cycle enable with pc_to_memctrl=0x0; return block {0x00400093,...} -> next cycle finish_sign_to_cmd=1, inst_to_cmd=0x00400093, pc_to_cmd=0, rollback_pc_to_cmd=4.
- Sequential hits at 0x0-0xC with full_sign=1 at 0x8 -> no issue and pc holds at 0x8 while full; resumes with pc_to_cmd=0x8 after release.
- Predictor taken, target 0x20 at pc=0x4 -> predicted_jump_sign_to_cmd=1; next fetch pc=0x24.
- 2 ways, SETS=16: fill 0x000, 0x100, then 0x200 (same set) with 0x000 last used -> 0x100 evicted; refetch of 0x000 hits.
- Rollback to 0x40 during FETCH, with memctrl finish in the same cycle -> rollback_sign_to_memctrl=1 for 1 cycle; stale block not written; new request with pc_to_memctrl=0x40.
- With ICACHE_NEXT_LINE_PREFETCH_EN: miss at 0x0 -> second enable with 0x10 after refill; pc 0x10 then hits with no further request.
